// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings, FSM states, default latencies.
// Used by the ID decoder, hazard unit and the mdu itself.
package mdu_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mul_op(
    input logic [2:0] op
  );
    return (op == MDU_MULT) ||
           (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(
    input logic [2:0] op
  );
    return (op == MDU_DIV) ||
           (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath for the mdu.
// Divide outputs exist only when MDU_DIV_EN is defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod
`ifdef MDU_DIV_EN
  ,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        dz
`endif
);

  logic               mul_sgn;
  logic signed [63:0] ma;
  logic signed [63:0] mb;

  assign mul_sgn = (op == MDU_MULT);

  always_comb begin
    ma = {{32{mul_sgn & a[31]}}, a};
    mb = {{32{mul_sgn & b[31]}}, b};
  end

  // low 64 bits of the extended product are exact for both signednesses
  assign prod = ma * mb;

`ifdef MDU_DIV_EN
  logic               div_sgn;
  logic signed [32:0] da;
  logic signed [32:0] db;
  logic signed [32:0] dbs;

  assign div_sgn = (op == MDU_DIV);
  assign dz      = (b == 32'd0);

  always_comb begin
    da   = {div_sgn & a[31], a};
    db   = {div_sgn & b[31], b};
    dbs  = dz ? 33'sd1 : db;
    quot = 32'(da / dbs);
    rem  = 32'(da % dbs);
  end
`endif

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// Divide support is built only when MDU_DIV_EN is defined.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  mdu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prod;
  logic        is_mul;
  logic        is_div;
  logic        is_mthi;
  logic        is_mtlo;

  assign is_mul  = is_mul_op(mdu_op);
  assign is_mthi = (mdu_op == MDU_MTHI);
  assign is_mtlo = (mdu_op == MDU_MTLO);

`ifdef MDU_DIV_EN
  logic [31:0] quot;
  logic [31:0] rem;
  logic        dz;

  assign is_div = is_div_op(mdu_op);

  mdu_arith u_arith (
    .op   (mdu_op),
    .a    (rs_data),
    .b    (rt_data),
    .prod (prod),
    .quot (quot),
    .rem  (rem),
    .dz   (dz)
  );
`else
  assign is_div = 1'b0;

  mdu_arith u_arith (
    .op   (mdu_op),
    .a    (rs_data),
    .b    (rt_data),
    .prod (prod)
  );
`endif

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = busy_q |
                     (start & (is_mul | is_div));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mul: begin
              pend_d  = prod;
              dz_d    = 1'b0;
              cnt_d   = CW'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
`ifdef MDU_DIV_EN
            is_div: begin
              pend_d  = {rem, quot};
              dz_d    = dz;
              cnt_d   = CW'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
`endif
            is_mthi: hi_d = rs_data;
            is_mtlo: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      RUN: begin
        // starts are ignored here; only the countdown advances
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (!dz_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit on the EX-side consumer end of the ID/EX pipeline register. It takes the operand pair latched into EX, performs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, and owns the HI/LO architectural registers. It drives a stall request back toward ID so the hazard logic can hold the front end and clear ID/EX while HI/LO are pending.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU
- DIV_CYCLES, 10, busy cycles for DIV/DIVU
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  EX instruction is an MDU op this cycle
- mdu_op  in  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO (shared encodings)
- rs_data  in  32  forwarded rs operand from EX
- rt_data  in  32  forwarded rt operand from EX
- busy  out  1  operation in flight
- stall_req  out  1  busy OR (start AND op is MULT/MULTU/DIV/DIVU); combinational, to ID hazard logic
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN. Reset -> IDLE; busy=0, hi=0, lo=0, counter=0, pending result=0.
- IDLE, start with MULT/MULTU: compute 64-bit signed/unsigned product of rs_data × rt_data into pending {hi,lo}; load counter=MULT_CYCLES; -> RUN.
- IDLE, start with DIV/DIVU: signed/unsigned quotient -> pending lo, remainder -> pending hi; remainder sign follows dividend (truncating division); load counter=DIV_CYCLES; -> RUN.
- Divide by zero: RUN entered normally with full DIV_CYCLES; commit is suppressed, so HI/LO keep their old values.
- IDLE, start with MTHI/MTLO: hi (resp. lo) <= rs_data at that edge; no RUN, busy never asserts.
- RUN: counter decrements each edge; on the edge where counter reaches 0, hi/lo <= pending, busy -> 0, -> IDLE.
- start during RUN is ignored: no restart, no MTHI/MTLO write. Hazard logic guarantees this does not occur; the bench checks that it is ignored.
- hi/lo hold their previous values throughout RUN; MFHI/MFLO are stalled by the hazard logic through stall_req.
- Unknown mdu_op with start: no effect.

## Timing
- Start sampled at edge E0. busy=1 during the MULT_CYCLES (or DIV_CYCLES) cycles following E0.
- At edge E(MULT_CYCLES) or E(DIV_CYCLES), busy falls and the new hi/lo become visible in the same cycle.
- Back-to-back: a start in the first cycle after busy falls is accepted.
- MTHI/MTLO latency: 1 edge.
- stall_req has zero latency: high in the start cycle itself.
- Reset asserted mid-RUN: busy, hi, lo go to 0 asynchronously; the pending result is discarded with no commit after reset release.

## Configuration
- MDU_DIV_EN defined: DIV/DIVU implemented as above.
- MDU_DIV_EN undefined: divider logic is not synthesized. DIV/DIVU with start behave as no-ops: no busy, stall_req=0, HI/LO unchanged. MULT/MTHI/MTLO are unaffected.

## Structure
- Shared package/definitions file holds the mdu_op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO), the state encodings, and the default cycle counts. The ID decoder and the hazard unit use the same definitions.
- One sub-module: mdu_arith. It is combinational and produces the 64-bit product and the quotient/remainder plus a div-by-zero flag. Its divide path is guarded by MDU_DIV_EN.
- mdu keeps the FSM, counter, pending registers, and HI/LO.

## Test plan
- MULT rs=0xFFFFFFFF, rt=0x00000002 -> busy for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU rs=0xFFFFFFFF, rt=0x00000002 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. During busy, hi/lo still show the prior values.
- DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. stall_req high in the start cycle.
- MTHI rs=0x12345678 -> hi=0x12345678 after 1 edge, busy stays 0. Then MULT, and during busy assert MTLO rs=0xAAAA5555 -> ignored, lo=MULT result.
- DIVU rs=0x00000064, rt=0 -> busy for 10 cycles; hi/lo unchanged afterward.
- DIV in progress, assert reset in the 4th busy cycle -> busy=0, hi=lo=0 immediately; no commit after release. With MDU_DIV_EN undefined, DIV -> busy never asserts.
